// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: PC geometry, PC-sequencer state type and the
// ALU-op / funct encodings that the decode controls and the sequencer agree on.
package mips16_pkg;

  localparam int              PC_W        = 16;
  localparam logic [15:0]     RESET_VEC   = 16'h0000;
  localparam int              INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FAULT = 2'd3
  } pcseq_state_t;

  // aluop from the main control; R-type defers to the funct field
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [3:0] FUNCT_JR    = 4'b1000;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC adders: sequential successor (also the link address)
// and the PC-relative branch target, both wrapping modulo 2**PC_W.
module pc_target_calc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] br_offset_i,
  output logic [PC_W-1:0] seq_pc_o,
  output logic [PC_W-1:0] br_pc_o
);
  import mips16_pkg::*;

  assign seq_pc_o = pc_i + PC_W'(INSTR_BYTES);
  // offset counts instructions, so scale to bytes before adding
  assign br_pc_o  = seq_pc_o + (br_offset_i << 1);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, jr/branch redirects followed by a
// fixed flush bubble, jal link capture and a sticky misaligned-jr fault.
module pc_sequencer #(
  parameter int              PC_W         = mips16_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_VEC    = mips16_pkg::RESET_VEC,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            jr_sel,
  input  logic [PC_W-1:0] jr_target,
  input  logic            br_take,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jal,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic [PC_W-1:0] link_addr,
  output logic            misaligned
);
  import mips16_pkg::*;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  pcseq_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] link_q;
  logic [1:0]      cnt_q;
  logic            fetch_valid_q;
  logic            flush_q;
  logic            misaligned_q;

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_pc;

  pc_target_calc #(.PC_W(PC_W)) u_calc (
    .pc_i        (pc_q),
    .br_offset_i (br_offset),
    .seq_pc_o    (seq_pc),
    .br_pc_o     (br_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      link_q        <= '0;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (!stall) begin
            if (jr_sel) begin
              if (jr_target[0]) begin
                state_q       <= FAULT;
                misaligned_q  <= 1'b1;
                fetch_valid_q <= 1'b0;
                flush_q       <= 1'b1;
              end else begin
                pc_q          <= jr_target;
                if (jal) link_q <= seq_pc;
                state_q       <= FLUSH;
                cnt_q         <= CNT_INIT;
                fetch_valid_q <= 1'b0;
                flush_q       <= 1'b1;
              end
            end else if (br_take) begin
              pc_q          <= br_pc;
              if (jal) link_q <= seq_pc;
              state_q       <= FLUSH;
              cnt_q         <= CNT_INIT;
              fetch_valid_q <= 1'b0;
              flush_q       <= 1'b1;
            end else begin
              pc_q <= seq_pc;
            end
          end
        end
        FLUSH: begin
          // requests arriving here belong to squashed instructions
          if (!stall) begin
            if (cnt_q == 2'd0) begin
              state_q       <= RUN;
              fetch_valid_q <= 1'b1;
              flush_q       <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign link_addr   = link_q;
  assign misaligned  = misaligned_q;

endmodule
